ball_engine: RTL



---
 rtl/pong_pkg.sv | 24 ++
 rtl/ball_engine_step_timer.sv | 53 +++++
 rtl/ball_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared playfield constants and the ball state encoding used
//               by the game controller, the renderer and the ball engine.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Playfield is 256x256; the ball starts each rally at the centre.
  localparam logic [7:0] FIELD_MAX   = 8'd255;
  localparam logic [7:0] CENTER      = 8'd128;

  // Step period is PERIOD_BASE - speed - boost game_clk cycles.
  localparam logic [5:0] PERIOD_BASE = 6'd32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    OUT_L = 2'd1,
    OUT_R = 2'd2
  } ball_state_e;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/ball_engine_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Step-rate divider for the ball engine. Counts enabled cycles
//               and pulses tick once every P = 32 - speed - boost cycles.
// Ports       : game_clk  - game clock
//               speed     - move rate, only meaningful while enable is high
//               boost     - per-rally speed boost
//               enable    - count this cycle (ball running, speed > 0)
//               clear     - synchronous counter clear, wins over enable
//               tick      - one-cycle step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer
  import pong_pkg::*;
(
  input  logic       game_clk,
  input  logic [4:0] speed,
  input  logic [2:0] boost,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  logic [5:0] period;
  logic [5:0] count_q;
  logic [5:0] count_d;

  assign period = PERIOD_BASE - {1'b0, speed} - {3'b000, boost};

  // A shrinking period can leave the count already past the new terminal
  // value; the >= compare fires the step on the next cycle in that case.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = 6'd0;
    end else if (enable) begin
      if (count_q >= (period - 6'd1)) begin
        tick    = 1'b1;
        count_d = 6'd0;
      end else begin
        count_d = count_q + 6'd1;
      end
    end
  end

  always_ff @(posedge game_clk) begin
    count_q <= count_d;
  end

endmodule : step_timer
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_engine
// Description : Ball motion engine for the pong playfield. Moves the ball one
//               pixel per step in x (and in y every step or every other step,
//               by slope), bounces off walls and paddles, and raises a sticky
//               miss flag when the ball reaches an edge column.
// Ports       : game_clk  - 1 kHz game clock
//               reset     - synchronous active-high rally restart
//               entropy   - direction/slope seed, sampled only during reset
//               speed     - signed move rate, <= 0 freezes the ball
//               lpaddle   - left paddle map, bit i covers rows 16i..16i+15
//               rpaddle   - right paddle map, same encoding
//               x, y      - registered ball position
//               out_left  - ball passed the left paddle (sticky)
//               out_right - ball passed the right paddle (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module ball_engine
  import pong_pkg::*;
#(
  parameter int PADDLE_L_X = 8,
  parameter int PADDLE_R_X = 247,
  parameter int BOOST_MAX  = 7
) (
  input  logic        game_clk,
  input  logic        reset,
  input  logic [4:0]  entropy,
  input  logic [4:0]  speed,
  input  logic [15:0] lpaddle,
  input  logic [15:0] rpaddle,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        out_left,
  output logic        out_right
);

  localparam logic [7:0] L_FACE    = 8'(PADDLE_L_X);
  localparam logic [7:0] R_FACE    = 8'(PADDLE_R_X);
  localparam logic [2:0] BOOST_CAP = 3'(BOOST_MAX);

  ball_state_e state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        dx_q, dx_d;        // 1 = moving right (+1)
  logic        dy_q, dy_d;        // 1 = moving down (+1)
  logic        slope_q, slope_d;  // 1 = y moves every step
  logic        yphase_q, yphase_d;
  logic [2:0]  boost_q, boost_d;

  logic        speed_pos;
  logic        timer_en;
  logic        tick;
  logic        l_hit;
  logic        r_hit;
  logic [7:0]  x_free;
  logic [2:0]  boost_inc;
  logic        unused_entropy;

  assign unused_entropy = ^entropy[4:3];

  assign speed_pos = !speed[4] && (speed != 5'd0);
  assign timer_en  = (state_q == RUN) && speed_pos;

  step_timer u_step_timer (
    .game_clk (game_clk),
    .speed    (speed),
    .boost    (boost_q),
    .enable   (timer_en),
    .clear    (reset),
    .tick     (tick)
  );

  // Paddle lookup uses the row band of the pre-step y.
  assign l_hit     = !dx_q && (x_q == L_FACE) && lpaddle[y_q[7:4]];
  assign r_hit     =  dx_q && (x_q == R_FACE) && rpaddle[y_q[7:4]];
  assign x_free    = dx_q ? (x_q + 8'd1) : (x_q - 8'd1);
  assign boost_inc = (boost_q < BOOST_CAP) ? (boost_q + 3'd1) : boost_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    slope_d  = slope_q;
    yphase_d = yphase_q;
    boost_d  = boost_q;

    if (reset) begin
      state_d  = RUN;
      x_d      = CENTER;
      y_d      = CENTER;
      dx_d     = entropy[0];
      dy_d     = entropy[1];
      slope_d  = entropy[2];
      yphase_d = 1'b0;
      boost_d  = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            yphase_d = ~yphase_q;

            if (l_hit) begin
              dx_d    = 1'b1;
              x_d     = x_q + 8'd1;
              boost_d = boost_inc;
            end else if (r_hit) begin
              dx_d    = 1'b0;
              x_d     = x_q - 8'd1;
              boost_d = boost_inc;
            end else begin
              x_d = x_free;
              if (x_free == 8'd0) begin
                state_d = OUT_L;
              end else if (x_free == FIELD_MAX) begin
                state_d = OUT_R;
              end
            end

            // Shallow slope moves y only on even-phase steps.
            if (slope_q || !yphase_q) begin
              if (!dy_q && (y_q == 8'd0)) begin
                dy_d = 1'b1;
                y_d  = 8'd1;
              end else if (dy_q && (y_q == FIELD_MAX)) begin
                dy_d = 1'b0;
                y_d  = FIELD_MAX - 8'd1;
              end else begin
                y_d = dy_q ? (y_q + 8'd1) : (y_q - 8'd1);
              end
            end
          end
        end
        OUT_L, OUT_R: begin
          // Ball parked at the exit column until the next reset.
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge game_clk) begin
    state_q  <= state_d;
    x_q      <= x_d;
    y_q      <= y_d;
    dx_q     <= dx_d;
    dy_q     <= dy_d;
    slope_q  <= slope_d;
    yphase_q <= yphase_d;
    boost_q  <= boost_d;
  end

  assign x         = x_q;
  assign y         = y_q;
  assign out_left  = (state_q == OUT_L);
  assign out_right = (state_q == OUT_R);

endmodule : ball_engine
`default_nettype wire
